// File: rtl/mul_pkg.sv
// Shared definitions for the multiply sequencing logic.
//   - default operand width and WAIT timeout
//   - FSM state encoding
//   - conditional two's-complement negate helper
package mul_pkg;

  localparam int unsigned MUL_WIDTH    = 32;
  localparam int unsigned MUL_TIMEOUT  = 40;
  // Widest value the helper handles; covers the product at the default width.
  localparam int unsigned MUL_MAX_PROD = 2 * MUL_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StGuard,
    StWait,
    StFix,
    StResp
  } state_e;

  // Returns -x (mod 2^MUL_MAX_PROD) when neg is set, else x. Negating zero yields zero.
  function automatic logic [MUL_MAX_PROD-1:0] twos_neg(input logic [MUL_MAX_PROD-1:0] x,
                                                      input logic                    neg);
    return neg ? (~x + MUL_MAX_PROD'(1)) : x;
  endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Combinational sign handling around the unsigned multiplier.
//   a, b        : raw request operands
//   is_signed   : operands are two's complement
//   prod        : captured unsigned product of the magnitudes
//   prod_neg    : latched result sign
//   mag_a/mag_b : operand magnitudes (the most negative value maps to 2^(WIDTH-1))
//   neg         : result sign for the current request
//   prod_fixed  : sign-corrected product
module mul_sign_fix
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  input  logic [2*WIDTH-1:0] prod,
  input  logic               prod_neg,
  output logic [WIDTH-1:0]   mag_a,
  output logic [WIDTH-1:0]   mag_b,
  output logic               neg,
  output logic [2*WIDTH-1:0] prod_fixed
);

  logic [MUL_MAX_PROD-1:0] prod_w;

  assign mag_a = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign mag_b = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign neg   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);

  // The low 2*WIDTH bits of a wide negate equal the narrow negate.
  assign prod_w     = twos_neg(MUL_MAX_PROD'(prod), prod_neg);
  assign prod_fixed = prod_w[2*WIDTH-1:0];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Issue/sequencing stage in front of the iterative shift-add multiplier.
//   clk, rst                 : clock, async active-high reset
//   req_valid/req_ready      : request handshake carrying req_a, req_b, req_signed
//   mul_start                : one-cycle start pulse to the multiplier
//   mul_multiplicand/_multiplier : operand magnitudes, held from ISSUE until WAIT exits
//   mul_product, mul_finish  : multiplier result and level done flag
//   resp_valid/resp_ready    : response handshake carrying resp_product, resp_err
// TIMEOUT must exceed WIDTH+2 so a healthy multiplier never trips the guard.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH   = MUL_WIDTH,
  parameter int unsigned TIMEOUT = MUL_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic               req_signed,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_multiplicand,
  output logic [WIDTH-1:0]   mul_multiplier,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic               mul_finish,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [2*WIDTH-1:0] resp_product,
  output logic               resp_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] prod_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_d;
  logic [2*WIDTH-1:0] prod_fixed;

  mul_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .a          (req_a),
    .b          (req_b),
    .is_signed  (req_signed),
    .prod       (prod_q),
    .prod_neg   (neg_q),
    .mag_a      (mag_a),
    .mag_b      (mag_b),
    .neg        (neg_d),
    .prod_fixed (prod_fixed)
  );

  // Low while reset is held, even though the state register already reads IDLE.
  assign req_ready = (state_q == StIdle) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      neg_q            <= 1'b0;
      prod_q           <= '0;
      mul_start        <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      resp_valid       <= 1'b0;
      resp_product     <= '0;
      resp_err         <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            mul_multiplicand <= mag_a;
            mul_multiplier   <= mag_b;
            neg_q            <= neg_d;
            mul_start        <= 1'b1;
            state_q          <= StIssue;
          end
        end
        StIssue: begin
          mul_start <= 1'b0;
          state_q   <= StGuard;
        end
        StGuard: begin
          // mul_finish may still be high from the previous operation; skip it here.
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_q + CntW'(1);
          if (mul_finish) begin
            prod_q  <= mul_product;
            state_q <= StFix;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            resp_err     <= 1'b1;
            resp_product <= '0;
            resp_valid   <= 1'b1;
            state_q      <= StResp;
          end
        end
        StFix: begin
          resp_product <= prod_fixed;
          resp_err     <= 1'b0;
          resp_valid   <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a behavioural iterative multiplier model.
module tb_mul_seq_ctrl;

  localparam int LAT     = 32;
  localparam int TIMEOUT = 40;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_signed;
  logic        mul_start;
  logic [31:0] mul_multiplicand;
  logic [31:0] mul_multiplier;
  logic [63:0] mul_product;
  logic        mul_finish;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_product;
  logic        resp_err;

  int vectors;
  int miscompares;

  // Model knobs
  logic hang;        // never raise finish
  logic stale_mode;  // keep the old finish high one cycle past start
  logic busy;
  int   mcnt;

  mul_seq_ctrl #(
    .WIDTH   (32),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_a            (req_a),
    .req_b            (req_b),
    .req_signed       (req_signed),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_product      (mul_product),
    .mul_finish       (mul_finish),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_product     (resp_product),
    .resp_err         (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: LAT cycles after the start pulse, finish rises and stays high.
  // The product is formed from the operands as seen at the end, so unstable operands show up.
  always @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      mcnt        <= 0;
      mul_finish  <= 1'b0;
      mul_product <= '0;
    end else if (mul_start) begin
      busy <= 1'b1;
      mcnt <= 0;
      if (!stale_mode) mul_finish <= 1'b0;
    end else if (busy) begin
      mcnt <= mcnt + 1;
      if (mcnt == 0) mul_finish <= 1'b0;
      if (mcnt == LAT - 1) begin
        busy <= 1'b0;
        if (!hang) begin
          mul_finish  <= 1'b1;
          mul_product <= {32'b0, mul_multiplicand} * {32'b0, mul_multiplier};
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Offer a request, wait (bounded) for acceptance, then check the one-cycle start pulse.
  // Returns one edge after acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
    int n;
    n          = 0;
    req_a      = a;
    req_b      = b;
    req_signed = s;
    req_valid  = 1'b1;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("start_high", 64'(mul_start), 64'd1);
    @(posedge clk); #1;
    chk("start_low", 64'(mul_start), 64'd0);
  endtask

  // Wait (bounded) for resp_valid and check the result; exp_n < 0 skips the latency check.
  task automatic wait_resp(input string tag, input logic [63:0] exp_p, input logic exp_e,
                           input int exp_n);
    int n;
    n = 1;
    while (!resp_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, "_product"}, resp_product, exp_p);
    chk({tag, "_err"}, 64'(resp_err), 64'(exp_e));
    if (exp_n >= 0) chk({tag, "_latency"}, 64'(n), 64'(exp_n));
    if (resp_ready) begin
      @(posedge clk); #1;
      chk({tag, "_valid_drop"}, 64'(resp_valid), 64'd0);
      chk({tag, "_idle_ready"}, 64'(req_ready), 64'd1);
    end
  endtask

  initial begin
    logic seen;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_a       = '0;
    req_b       = '0;
    req_signed  = 1'b0;
    resp_ready  = 1'b1;
    hang        = 1'b0;
    stale_mode  = 1'b0;

    @(posedge clk); #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_start", 64'(mul_start), 64'd0);
    chk("rst_mcand", 64'(mul_multiplicand), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_product", resp_product, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("idle_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // Basic unsigned, with end-to-end latency
    send(32'd3, 32'd5, 1'b0);
    wait_resp("u3x5", 64'h0000_0000_0000_000F, 1'b0, LAT + 3);

    send(32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_resp("sm3x5", 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, LAT + 3);

    send(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_resp("smin2", 64'h4000_0000_0000_0000, 1'b0, -1);

    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_resp("umax2", 64'hFFFF_FFFE_0000_0001, 1'b0, -1);

    send(32'd7, 32'hFFFF_FFF7, 1'b1);
    wait_resp("s7xm9", 64'hFFFF_FFFF_FFFF_FFC1, 1'b0, -1);

    send(32'd0, 32'hFFFF_FFFB, 1'b1);
    wait_resp("s0xm5", 64'd0, 1'b0, -1);

    // Backpressure, with the next request already offered
    resp_ready = 1'b0;
    send(32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1);
    wait_resp("bp", 64'd6, 1'b0, -1);
    req_a      = 32'h10;
    req_b      = 32'h20;
    req_signed = 1'b0;
    req_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 64'(resp_valid), 64'd1);
      chk("bp_hold_product", resp_product, 64'd6);
      chk("bp_hold_err", 64'(resp_err), 64'd0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_drop", 64'(resp_valid), 64'd0);
    chk("bp_idle_ready", 64'(req_ready), 64'd1);
    send(32'h10, 32'h20, 1'b0);
    wait_resp("bp_next", 64'h200, 1'b0, LAT + 3);

    // Stale finish carried into ISSUE and GUARD
    stale_mode = 1'b1;
    send(32'h1234, 32'h10, 1'b0);
    wait_resp("stale", 64'h12340, 1'b0, LAT + 3);
    stale_mode = 1'b0;

    // Timeout
    hang = 1'b1;
    send(32'd9, 32'd9, 1'b0);
    wait_resp("timeout", 64'd0, 1'b1, TIMEOUT + 2);
    hang = 1'b0;

    // Async reset in WAIT
    send(32'h11, 32'h22, 1'b0);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mrst_req_ready", 64'(req_ready), 64'd0);
    chk("mrst_start", 64'(mul_start), 64'd0);
    chk("mrst_mcand", 64'(mul_multiplicand), 64'd0);
    chk("mrst_mplier", 64'(mul_multiplier), 64'd0);
    chk("mrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("mrst_resp_product", resp_product, 64'd0);
    chk("mrst_resp_err", 64'(resp_err), 64'd0);
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT + 10; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    chk("mrst_no_resp", 64'(seen), 64'd0);
    send(32'd6, 32'd7, 1'b0);
    wait_resp("after_rst", 64'd42, 1'b0, LAT + 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
Issue/sequencing stage that sits directly upstream of the 32-bit iterative shift-add multiplier. It accepts signed or unsigned multiply requests over a valid/ready handshake and converts signed operands to magnitudes. It pulses the multiplier's start, holds the operands stable, waits for finish (with a timeout guard), fixes the sign of the 64-bit product, and presents it downstream over a second valid/ready handshake.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH.
TIMEOUT, 40, maximum WAIT cycles before an error response is raised; must be greater than WIDTH+2.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request offered
req_ready  output  1  request accepted when valid&ready
req_a  input  WIDTH  multiplicand
req_b  input  WIDTH  multiplier
req_signed  input  1  1 = two's-complement operands, 0 = unsigned
mul_start  output  1  start pulse to the multiplier (registered)
mul_multiplicand  output  WIDTH  operand to the multiplier (registered)
mul_multiplier  output  WIDTH  operand to the multiplier (registered)
mul_product  input  2*WIDTH  multiplier result
mul_finish  input  1  multiplier done (level; stays high once done)
resp_valid  output  1  result available
resp_ready  input  1  downstream accepts the result when valid&ready
resp_product  output  2*WIDTH  final (sign-corrected) product
resp_err  output  1  1 = timeout; resp_product is 0

Behaviour:
- Reset (async, active-high): state=IDLE. req_ready=0 during reset and 1 in IDLE after reset. mul_start=0, mul_multiplicand=0, mul_multiplier=0, resp_valid=0, resp_product=0, resp_err=0, timeout counter=0, neg flag=0. Reset mid-operation drops any in-flight request silently; no response is produced.
- States: IDLE, ISSUE, GUARD, WAIT, FIX, RESP.
- IDLE: req_ready=1. On req_valid, latch the operands:
  - Signed: magnitude = bit[WIDTH-1] ? ~x+1 : x. The most negative value maps to 2^(WIDTH-1) and is valid unsigned.
  - neg = req_signed & (a[MSB]^b[MSB]).
  - Unsigned: pass the operands through and set neg=0.
  - Go to ISSUE.
- ISSUE: mul_start=1 for exactly this one cycle. Go to GUARD.
- GUARD: mul_start=0. Ignore mul_finish, because a stale high from the previous operation is possible. Clear the counter. Go to WAIT.
- WAIT: increment the counter every cycle.
  - mul_finish=1: capture mul_product and go to FIX.
  - Otherwise, if counter==TIMEOUT-1: set resp_err=1, resp_product=0, and go to RESP.
- FIX: resp_product = neg ? (~captured+1) mod 2^(2*WIDTH) : captured. resp_err=0. Go to RESP.
- RESP: resp_valid=1, and resp_product/resp_err are held stable while resp_ready=0. On resp_ready: resp_valid drops next cycle, state goes to IDLE, and req_ready=1 from that cycle. There is no request/response overlap; throughput is one operation in flight.
- Operand stability: mul_multiplicand and mul_multiplier are held constant from ISSUE through the exit of WAIT, because the multiplier reads its operand bits every iteration. They change only on request acceptance.
- Latency:
  - Accept at edge 0; mul_start high during cycle 1; GUARD in cycle 2; WAIT from cycle 3.
  - If finish is sampled high at edge k, resp_valid is high from cycle k+2.
  - With the 32-iteration multiplier, end-to-end latency is about 37 cycles.
- Zero operands: product 0. Negating 0 yields 0, so the sign is always correct.
- req_valid while not in IDLE: ignored, since req_ready=0. The requester must hold the request.
- mul_finish high in ISSUE or GUARD: no effect.

Decomposition:
- Shared package, mul_pkg:
  - state encoding enum (IDLE..RESP)
  - WIDTH default
  - TIMEOUT default
  - helper function for two's-complement magnitude
- Optional sub-module: mul_sign_fix (combinational magnitude and negate).
- The FSM, counter and handshake stay in mul_seq_ctrl.
- The bench instantiates mul_seq_ctrl together with the iterative multiplier; a behavioural multiplier model is also acceptable.

Test Plan:
- Unsigned 0x0000_0003 × 0x0000_0005, resp_ready=1 -> one resp_valid pulse, resp_product=0x0000_0000_0000_000F, resp_err=0, mul_start high exactly 1 cycle.
- Signed -3 (0xFFFF_FFFD) × 5 -> resp_product=0xFFFF_FFFF_FFFF_FFF1. Signed 0x8000_0000 × 0x8000_0000 -> 0x4000_0000_0000_0000. Unsigned 0xFFFF_FFFF × 0xFFFF_FFFF -> 0xFFFF_FFFE_0000_0001.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid -> product and err stable, req_ready=0 throughout. Then resp_ready=1 -> IDLE next cycle and the next request is accepted.
- Stale finish: keep mul_finish high from the previous operation into the next request -> no early capture; the result equals the new operands' product.
- Timeout: a model that never asserts mul_finish -> resp_valid at cycle ISSUE+2+TIMEOUT with resp_err=1 and resp_product=0.
- Reset asserted in WAIT (async, mid-cycle) -> immediate IDLE, all outputs at reset values, no response. The next request completes correctly.
